dmem_responder: RTL and testbench

- Data-memory target for the single-cycle RV32 core; answers the core's DM_address / DM_data_o / DM_write_enable requests and supplies DM_data_i.
- Provides:
  - word RAM with byte-lane stores;
  - combinational, lane-aligned load data;
  - a small MMIO register page: cycle counter, LED port, misalignment fault register, halt/exit register.
- All state updates on posedge clk. Reads are combinational, so the core keeps its single-cycle load timing.

---
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory target for the single-cycle RV32 core: byte-lane word RAM with
// combinational lane-aligned loads, plus a word-only MMIO page (CYCLE, LEDS, FAULT, TOHOST).
module dmem_responder #(
  parameter int DATAWORDS = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic [7:0]  leds,
  output logic        halt,
  output logic [31:0] exit_code,
  output logic        fault
);

  localparam int AW = $clog2(DATAWORDS * 4);

  logic [31:0] mem [DATAWORDS];

  logic [31:0] cycle_q;
  logic [15:0] fault_cnt;

  logic          is_mmio, is_byte, is_half, is_word, misaligned;
  logic          wr_ok, ram_we, mmio_we;
  logic [AW-3:0] widx;
  logic [3:0]    offset;
  logic [31:0]   ram_word, ram_rdata, mmio_rdata;
  logic [3:0]    byte_en;
  logic [31:0]   wr_lanes;

  assign is_mmio = addr[31];
  assign is_byte = (funct3[1:0] == 2'b00);
  assign is_half = (funct3[1:0] == 2'b01);
  assign is_word = funct3[1];
  assign widx    = addr[AW-1:2];
  assign offset  = addr[3:0];

  // Sub-word MMIO accesses are simply ignored, so only RAM halves can misalign.
  assign misaligned = (we | re) &
                      (is_word ? (addr[1:0] != 2'b00) : (is_half & addr[0] & ~is_mmio));

  assign wr_ok   = we & ~misaligned;
  assign ram_we  = wr_ok & ~is_mmio;
  assign mmio_we = wr_ok & is_mmio & is_word;

  assign ram_word  = mem[widx];
  assign ram_rdata = ram_word >> {addr[1:0], 3'b000};

  always_comb begin
    mmio_rdata = 32'h0;
    case (offset)
      4'h0:    mmio_rdata = cycle_q;
      4'h4:    mmio_rdata = {24'h0, leds};
      4'h8:    mmio_rdata = {fault_cnt, 15'h0, fault};
      4'hC:    mmio_rdata = exit_code;
      default: mmio_rdata = 32'h0;
    endcase
  end

  always_comb begin
    rdata = 32'h0;
    if (!misaligned) begin
      if (is_mmio) rdata = is_word ? mmio_rdata : 32'h0;
      else         rdata = ram_rdata;
    end
  end

  // Replicate the lane value across the word so byte_en alone picks the target lanes.
  always_comb begin
    byte_en  = 4'b1111;
    wr_lanes = wdata;
    if (is_byte) begin
      byte_en  = 4'b0001 << addr[1:0];
      wr_lanes = {4{wdata[7:0]}};
    end else if (is_half) begin
      byte_en  = addr[1] ? 4'b1100 : 4'b0011;
      wr_lanes = {2{wdata[15:0]}};
    end
  end

  // RAM has no reset; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[widx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= 32'h0;
      leds      <= 8'h0;
      halt      <= 1'b0;
      exit_code <= 32'h0;
      fault     <= 1'b0;
      fault_cnt <= 16'h0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (mmio_we && offset == 4'h4) leds <= wdata[7:0];
      if (mmio_we && offset == 4'hC && !halt) begin
        halt      <= 1'b1;
        exit_code <= wdata;
      end
      // A FAULT-register clear takes priority over a fault on the same edge.
      if (mmio_we && offset == 4'h8) begin
        fault     <= 1'b0;
        fault_cnt <= 16'h0;
      end else if (misaligned) begin
        fault <= 1'b1;
        if (fault_cnt != 16'hFFFF) fault_cnt <= fault_cnt + 16'd1;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr[30:AW], funct3[2]};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: the driver issues one access per cycle and
// queues the expected observations; a negedge monitor drains and compares them.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] addr, wdata;
  logic        we, re;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic [7:0]  leds;
  logic        halt;
  logic [31:0] exit_code;
  logic        fault;

  dmem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .re        (re),
    .funct3    (funct3),
    .rdata     (rdata),
    .leds      (leds),
    .halt      (halt),
    .exit_code (exit_code),
    .fault     (fault)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int SEL_RDATA = 0, SEL_LEDS = 1, SEL_HALT = 2, SEL_EXIT = 3, SEL_FAULT = 4;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic expect_val(input int sel, input logic [31:0] val, input string name);
    exp_q.push_back(val);
    sel_q.push_back(sel);
    name_q.push_back(name);
  endtask

  // Driver protocol: inputs change 1ns after posedge and hold for one full cycle;
  // everything queued during that cycle is compared at the following negedge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e, act;
      int          s;
      string       n;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      case (s)
        SEL_LEDS:  act = {24'h0, leds};
        SEL_HALT:  act = {31'h0, halt};
        SEL_EXIT:  act = exit_code;
        SEL_FAULT: act = {31'h0, fault};
        default:   act = rdata;
      endcase
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic access(input logic w, input logic r, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    we = w; re = r; funct3 = f3; addr = a; wdata = d;
  endtask

  task automatic idle();
    access(1'b0, 1'b0, F_W, 32'h0, 32'h0);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] e, input string name);
    access(1'b0, 1'b1, f3, a, 32'h0);
    expect_val(SEL_RDATA, e, name);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    access(1'b1, 1'b0, f3, a, d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; funct3 = F_W; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, then CYCLE after ten edges out of reset
    idle();
    expect_val(SEL_LEDS, 32'h0, "rst_leds");
    expect_val(SEL_HALT, 32'h0, "rst_halt");
    expect_val(SEL_EXIT, 32'h0, "rst_exit");
    expect_val(SEL_FAULT, 32'h0, "rst_fault");
    for (int i = 0; i < 8; i++) idle();
    load(F_W, 32'h8000_0000, 32'd10, "cycle_10");
    load(F_W, 32'h8000_0008, 32'h0, "rst_fault_reg");

    // CYCLE wrap
    load(F_W, 32'h8000_0000, 32'hFFFF_FFFF, "cycle_forced");
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1 release dut.cycle_q;
    load(F_W, 32'h8000_0000, 32'h0, "cycle_wrap");

    // Word / byte / half loads
    store(F_W, 32'h100, 32'hDEAD_BEEF);
    load(F_W, 32'h100, 32'hDEAD_BEEF, "lw_100");
    load(F_B, 32'h103, 32'h0000_00DE, "lb_103");
    load(F_H, 32'h102, 32'h0000_DEAD, "lh_102");
    load(F_W, 32'h1100, 32'hDEAD_BEEF, "lw_alias");

    // Byte and half stores
    store(F_W, 32'h40, 32'h1122_3344);
    store(F_B, 32'h41, 32'h0000_00AA);
    load(F_W, 32'h40, 32'h1122_AA44, "sb_41");
    store(F_H, 32'h42, 32'h0000_BBCC);
    load(F_W, 32'h40, 32'hBBCC_AA44, "sh_42");

    // Misalignment
    access(1'b1, 1'b0, F_W, 32'h102, 32'h1234_5678);
    expect_val(SEL_RDATA, 32'h0, "sw_mis_rdata");
    load(F_W, 32'h100, 32'hDEAD_BEEF, "sw_mis_ram");
    expect_val(SEL_FAULT, 32'h1, "fault_set");
    load(F_W, 32'h8000_0008, 32'h0001_0001, "fault_reg_1");
    load(F_H, 32'h101, 32'h0, "lh_mis_rdata");
    load(F_W, 32'h8000_0008, 32'h0002_0001, "fault_reg_2");
    store(F_W, 32'h8000_0008, 32'h1234_5678);
    load(F_W, 32'h8000_0008, 32'h0, "fault_clear_reg");
    expect_val(SEL_FAULT, 32'h0, "fault_clear");

    // Store with concurrent load shows pre-store data
    store(F_W, 32'h200, 32'h1111_1111);
    access(1'b1, 1'b1, F_W, 32'h200, 32'h2222_2222);
    expect_val(SEL_RDATA, 32'h1111_1111, "we_re_prestore");
    load(F_W, 32'h200, 32'h2222_2222, "we_re_post");

    // LEDS
    store(F_W, 32'h8000_0004, 32'h0000_005A);
    load(F_W, 32'h8000_0004, 32'h0000_005A, "leds_read");
    expect_val(SEL_LEDS, 32'h5A, "leds_out");
    access(1'b1, 1'b0, F_B, 32'h8000_0004, 32'h0000_00FF);
    expect_val(SEL_RDATA, 32'h0, "sb_mmio_rdata");
    load(F_W, 32'h8000_0004, 32'h0000_005A, "leds_sb_ignored");
    expect_val(SEL_LEDS, 32'h5A, "leds_out_kept");
    expect_val(SEL_FAULT, 32'h0, "sb_mmio_nofault");

    // TOHOST
    store(F_W, 32'h8000_000C, 32'd7);
    load(F_W, 32'h8000_000C, 32'd7, "tohost_read");
    expect_val(SEL_HALT, 32'h1, "halt_set");
    expect_val(SEL_EXIT, 32'd7, "exit_7");
    store(F_W, 32'h8000_000C, 32'd9);
    idle();
    expect_val(SEL_EXIT, 32'd7, "exit_sticky");
    expect_val(SEL_HALT, 32'h1, "halt_sticky");

    // Mid-run reset: state cleared, store on the reset edge dropped, RAM kept
    access(1'b1, 1'b0, F_W, 32'h100, 32'h0000_0077);
    rst = 1'b1;
    expect_val(SEL_HALT, 32'h0, "mid_rst_halt");
    expect_val(SEL_LEDS, 32'h0, "mid_rst_leds");
    expect_val(SEL_EXIT, 32'h0, "mid_rst_exit");
    access(1'b0, 1'b1, F_W, 32'h8000_0000, 32'h0);
    rst = 1'b0;
    expect_val(SEL_RDATA, 32'h0, "mid_rst_cycle");
    load(F_W, 32'h100, 32'hDEAD_BEEF, "mid_rst_ram");

    idle();
    begin
      int budget;
      budget = 5;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
